// File: rtl/iir_crossover_pkg.sv
// Shared constants, FSM encoding and the production crossover coefficient set.
// Production set: 2nd-order Butterworth LP/HP pair, fc = 2 kHz at fs = 48 kHz, Q2.22.
`ifndef c_DATA_NBITS
`define c_DATA_NBITS 24
`endif

package iir_crossover_pkg;

    localparam int C_DATA_NBITS = `c_DATA_NBITS;
    localparam int C_COEF_NBITS = 24;
    localparam int C_COEF_FRAC  = 22;
    localparam int N_FILT       = 4;
    localparam int N_TAP        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_WB,
        ST_DONE
    } state_t;

    // Tap order is b0, b1, b2, a1, a2; a-terms are subtracted by the MAC.
    function automatic logic signed [C_COEF_NBITS-1:0] prod_coef(input logic       is_hp,
                                                                input logic [2:0] tap);
        logic signed [C_COEF_NBITS-1:0] c;
        c = '0;
        case (tap)
            3'd0:    c = is_hp ?  24'sd3485056 : 24'sd60402;
            3'd1:    c = is_hp ? -24'sd6970112 : 24'sd120804;
            3'd2:    c = is_hp ?  24'sd3485056 : 24'sd60402;
            3'd3:    c = -24'sd6849313;
            3'd4:    c =  24'sd2896616;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/xover_coef_rom.sv
// Coefficient lookup by filter (0..3 = L-LP, L-HP, R-LP, R-HP) and tap (0..4); combinational, no handshake.
module xover_coef_rom
    import iir_crossover_pkg::*;
#(
    parameter int COEF_NBITS = C_COEF_NBITS,
    parameter int COEF_FRAC  = C_COEF_FRAC,
    parameter int TEST_COEFS = 0
) (
    input  logic [1:0]                   i_filt,
    input  logic [2:0]                   i_tap,
    output logic signed [COEF_NBITS-1:0] o_coef
);

    localparam logic signed [COEF_NBITS-1:0] ONE  = COEF_NBITS'(1) << COEF_FRAC;
    localparam logic signed [COEF_NBITS-1:0] HALF = COEF_NBITS'(1) << (COEF_FRAC - 1);

    logic w_is_hp;

    always_comb begin
        w_is_hp = 1'b0;
        case (i_filt)
            2'd1, 2'd3: w_is_hp = 1'b1;
            default:    w_is_hp = 1'b0;
        endcase
    end

    always_comb begin
        o_coef = '0;
        if (TEST_COEFS != 0) begin
            // Bench set: LP y = x + x1, HP y = 0.5*x + 0.5*y1.
            if (!w_is_hp) begin
                if (i_tap == 3'd0 || i_tap == 3'd1) o_coef = ONE;
            end else begin
                if (i_tap == 3'd0)      o_coef = HALF;
                else if (i_tap == 3'd3) o_coef = -HALF;
            end
        end else begin
            o_coef = COEF_NBITS'(prod_coef(w_is_hp, i_tap));
        end
    end

endmodule

// File: rtl/iir_crossover.sv
// Stereo 2-way crossover: four DF-I biquads on one shared MAC, 26 cycles from i_sync to o_valid.
// No backpressure: an i_sync arriving while busy is dropped and latches o_ovr until reset.
module iir_crossover
    import iir_crossover_pkg::*;
#(
    parameter int DATA_NBITS = `c_DATA_NBITS,
    parameter int COEF_NBITS = C_COEF_NBITS,
    parameter int COEF_FRAC  = C_COEF_FRAC,
    parameter int TEST_COEFS = 0
) (
    input  logic                         i_mck,
    input  logic                         i_rst,
    input  logic                         i_sync,
    input  logic signed [DATA_NBITS-1:0] i_l24,
    input  logic signed [DATA_NBITS-1:0] i_r24,
    output logic signed [DATA_NBITS-1:0] o_l_lp_24,
    output logic signed [DATA_NBITS-1:0] o_l_hp_24,
    output logic signed [DATA_NBITS-1:0] o_r_lp_24,
    output logic signed [DATA_NBITS-1:0] o_r_hp_24,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_ovr
);

    localparam int PROD_W = DATA_NBITS + COEF_NBITS;
    localparam int ACC_W  = PROD_W + 3;

    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W - COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
    localparam logic signed [DATA_NBITS-1:0] SAT_MAX = {1'b0, {(DATA_NBITS - 1){1'b1}}};
    localparam logic signed [DATA_NBITS-1:0] SAT_MIN = {1'b1, {(DATA_NBITS - 1){1'b0}}};

    state_t r_state, w_state_nxt;

    logic [1:0] r_flt;
    logic [2:0] r_tap;

    logic signed [DATA_NBITS-1:0] r_xin [2];
    logic signed [DATA_NBITS-1:0] r_x1  [2];
    logic signed [DATA_NBITS-1:0] r_x2  [2];
    logic signed [DATA_NBITS-1:0] r_y1  [N_FILT];
    logic signed [DATA_NBITS-1:0] r_y2  [N_FILT];
    logic signed [ACC_W-1:0]      r_acc;

    logic signed [DATA_NBITS-1:0] r_l_lp, r_l_hp, r_r_lp, r_r_hp;
    logic                         r_ovr;

    logic                         w_ch;
    logic signed [COEF_NBITS-1:0] w_coef;
    logic signed [DATA_NBITS-1:0] w_opnd;
    logic signed [PROD_W-1:0]     w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;
    logic signed [ACC_W-1:0]      w_rnd;
    logic signed [ACC_W-1:0]      w_shift;
    logic signed [DATA_NBITS-1:0] w_sat;

    assign w_ch = r_flt[1];

    xover_coef_rom #(
        .COEF_NBITS (COEF_NBITS),
        .COEF_FRAC  (COEF_FRAC),
        .TEST_COEFS (TEST_COEFS)
    ) u_rom (
        .i_filt (r_flt),
        .i_tap  (r_tap),
        .o_coef (w_coef)
    );

    always_comb begin
        w_opnd = '0;
        case (r_tap)
            3'd0:    w_opnd = r_xin[w_ch];
            3'd1:    w_opnd = r_x1[w_ch];
            3'd2:    w_opnd = r_x2[w_ch];
            3'd3:    w_opnd = r_y1[r_flt];
            3'd4:    w_opnd = r_y2[r_flt];
            default: w_opnd = '0;
        endcase
    end

    assign w_prod     = w_opnd * w_coef;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Round half up, then clamp when the shifted value no longer fits the sample width.
    assign w_rnd   = r_acc + RND_HALF;
    assign w_shift = w_rnd >>> COEF_FRAC;

    always_comb begin
        w_sat = w_shift[DATA_NBITS-1:0];
        if (!((&w_shift[ACC_W-1:DATA_NBITS-1]) || !(|w_shift[ACC_W-1:DATA_NBITS-1]))) begin
            w_sat = w_shift[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge i_mck or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_valid     = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_sync) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: w_state_nxt = ST_MAC;
            ST_MAC:  if (r_tap == 3'd4) w_state_nxt = ST_WB;
            ST_WB:   w_state_nxt = (r_flt == 2'd3) ? ST_DONE : ST_MAC;
            ST_DONE: begin
                o_valid     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_mck or posedge i_rst) begin
        if (i_rst) begin
            r_flt  <= '0;
            r_tap  <= '0;
            r_acc  <= '0;
            r_ovr  <= 1'b0;
            r_l_lp <= '0;
            r_l_hp <= '0;
            r_r_lp <= '0;
            r_r_hp <= '0;
            for (int i = 0; i < 2; i++) begin
                r_xin[i] <= '0;
                r_x1[i]  <= '0;
                r_x2[i]  <= '0;
            end
            for (int i = 0; i < N_FILT; i++) begin
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            if (i_sync && r_state != ST_IDLE) r_ovr <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    // Samples are only guaranteed valid alongside the accepted sync pulse.
                    if (i_sync) begin
                        r_xin[0] <= i_l24;
                        r_xin[1] <= i_r24;
                    end
                end
                ST_LOAD: begin
                    r_acc <= '0;
                    r_flt <= '0;
                    r_tap <= '0;
                end
                ST_MAC: begin
                    r_acc <= (r_tap >= 3'd3) ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
                    r_tap <= r_tap + 3'd1;
                end
                ST_WB: begin
                    r_y1[r_flt] <= w_sat;
                    r_y2[r_flt] <= r_y1[r_flt];
                    // LP and HP of a channel share x history, so it advances only after HP.
                    if (r_flt[0]) begin
                        r_x1[w_ch] <= r_xin[w_ch];
                        r_x2[w_ch] <= r_x1[w_ch];
                    end
                    if (r_flt == 2'd3) begin
                        r_l_lp <= r_y1[0];
                        r_l_hp <= r_y1[1];
                        r_r_lp <= r_y1[2];
                        r_r_hp <= w_sat;
                    end
                    r_acc <= '0;
                    r_tap <= '0;
                    r_flt <= r_flt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_l_lp_24 = r_l_lp;
    assign o_l_hp_24 = r_l_hp;
    assign o_r_lp_24 = r_r_lp;
    assign o_r_hp_24 = r_r_hp;
    assign o_ovr     = r_ovr;

endmodule

// File: tb/tb_iir_crossover.sv
// Table-driven bench for iir_crossover with the bench coefficient set and a frame scoreboard.
module tb_iir_crossover;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] llp;
        logic [23:0] lhp;
        logic [23:0] rlp;
        logic [23:0] rhp;
    } vec_t;

    logic        i_mck = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_sync = 1'b0;
    logic [23:0] i_l24 = '0;
    logic [23:0] i_r24 = '0;
    logic signed [23:0] o_l_lp_24, o_l_hp_24, o_r_lp_24, o_r_hp_24;
    logic        o_valid, o_busy, o_ovr;

    int   n_err = 0;
    int   n_chk = 0;
    vec_t tbl [5];
    vec_t sbq [$];

    iir_crossover #(
        .DATA_NBITS (24),
        .COEF_NBITS (24),
        .COEF_FRAC  (22),
        .TEST_COEFS (1)
    ) dut (
        .i_mck     (i_mck),
        .i_rst     (i_rst),
        .i_sync    (i_sync),
        .i_l24     (i_l24),
        .i_r24     (i_r24),
        .o_l_lp_24 (o_l_lp_24),
        .o_l_hp_24 (o_l_hp_24),
        .o_r_lp_24 (o_r_lp_24),
        .o_r_hp_24 (o_r_hp_24),
        .o_valid   (o_valid),
        .o_busy    (o_busy),
        .o_ovr     (o_ovr)
    );

    always #5 i_mck = ~i_mck;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input vec_t e);
        chk({tag, "_llp"}, o_l_lp_24, e.llp);
        chk({tag, "_lhp"}, o_l_hp_24, e.lhp);
        chk({tag, "_rlp"}, o_r_lp_24, e.rlp);
        chk({tag, "_rhp"}, o_r_hp_24, e.rhp);
    endtask

    task automatic reset_dut();
        vec_t z;
        z = '{l: '0, r: '0, llp: '0, lhp: '0, rlp: '0, rhp: '0};
        @(negedge i_mck);
        i_rst  = 1'b1;
        i_sync = 1'b0;
        repeat (3) @(negedge i_mck);
        i_rst = 1'b0;
        sbq.delete();
        repeat (100) @(negedge i_mck);
        chk_outs("rst", z);
        chk("rst_valid", {23'd0, o_valid}, 24'd0);
        chk("rst_busy",  {23'd0, o_busy},  24'd0);
        chk("rst_ovr",   {23'd0, o_ovr},   24'd0);
    endtask

    // Sync is sampled at the first posedge after it is driven (cycle 0); k counts cycles after that.
    task automatic run_frame(input vec_t v, input int ovr_at, input int rst_at);
        int   k;
        bit   seen;
        vec_t e;
        vec_t z;
        z = '{l: '0, r: '0, llp: '0, lhp: '0, rlp: '0, rhp: '0};
        @(negedge i_mck);
        i_l24  = v.l;
        i_r24  = v.r;
        i_sync = 1'b1;
        if (rst_at == 0) sbq.push_back(v);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            @(posedge i_mck);
            k++;
            @(negedge i_mck);
            i_sync = (ovr_at != 0 && k == ovr_at);
            i_rst  = (rst_at != 0 && k == rst_at);
            if (ovr_at != 0 && k == ovr_at) begin
                i_l24 = 24'h7FFFFF;
                i_r24 = 24'h7FFFFF;
            end
            if (k == 1) chk("busy_load", {23'd0, o_busy}, 24'd1);
            if (o_valid) seen = 1'b1;
        end
        i_sync = 1'b0;
        i_rst  = 1'b0;
        if (rst_at != 0) begin
            chk("abort_no_valid", {23'd0, seen}, 24'd0);
            chk_outs("abort", z);
            return;
        end
        chk("latency", 24'(k), 24'd26);
        if (seen && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk_outs("frame", e);
            chk("valid_busy", {23'd0, o_busy}, 24'd1);
            chk("ovr", {23'd0, o_ovr}, (ovr_at != 0) ? 24'd1 : 24'd0);
            @(negedge i_mck);
            chk("valid_pulse", {23'd0, o_valid}, 24'd0);
            chk("idle_busy",   {23'd0, o_busy},  24'd0);
            chk_outs("hold", e);
        end
    endtask

    initial begin
        int   extra;
        vec_t v;

        tbl[0] = '{l: 24'h100000, r: 24'h700000, llp: 24'h100000, lhp: 24'h080000, rlp: 24'h700000, rhp: 24'h380000};
        tbl[1] = '{l: 24'h100000, r: 24'h700000, llp: 24'h200000, lhp: 24'h0C0000, rlp: 24'h7FFFFF, rhp: 24'h540000};
        tbl[2] = '{l: 24'hF00000, r: 24'h800000, llp: 24'h000000, lhp: 24'hFE0000, rlp: 24'hF00000, rhp: 24'hEA0000};
        tbl[3] = '{l: 24'h000003, r: 24'h800000, llp: 24'hF00003, lhp: 24'hFF0002, rlp: 24'h800000, rhp: 24'hB50000};
        tbl[4] = '{l: 24'h7FFFFF, r: 24'h000001, llp: 24'h7FFFFF, lhp: 24'h3F8001, rlp: 24'h800001, rhp: 24'hDA8001};

        reset_dut();
        for (int i = 0; i < 5; i++) run_frame(tbl[i], 0, 0);

        // Negative half rounds up to zero on the HP path.
        reset_dut();
        v = '{l: 24'h000000, r: 24'hFFFFFF, llp: 24'h000000, lhp: 24'h000000, rlp: 24'hFFFFFF, rhp: 24'h000000};
        run_frame(v, 0, 0);

        // Second sync mid-frame is dropped, frame results are unaffected, overrun sticks.
        reset_dut();
        v = '{l: 24'h100000, r: 24'h000000, llp: 24'h100000, lhp: 24'h080000, rlp: 24'h000000, rhp: 24'h000000};
        run_frame(v, 10, 0);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge i_mck);
            if (o_valid) extra++;
        end
        chk("ovr_extra_valid", 24'(extra), 24'd0);
        chk("ovr_sticky", {23'd0, o_ovr}, 24'd1);

        // Reset in cycle 12 aborts the frame; the next frame starts from clean history.
        reset_dut();
        run_frame(v, 0, 12);
        run_frame(v, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
